// File: rtl/sbs_to_binary_if.sv
// Handshake/bus bundle for sbs_to_binary.
// master: the side that requests conversions, feeds the SBS stream and
//         consumes results.
// slave : the converter itself.
interface sbs_to_binary_if #(
    parameter int CW = 4
) ();
    logic          start;
    logic          sbs_in;
    logic          busy;
    logic [CW-1:0] count_out;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output start,
        output sbs_in,
        output out_ready,
        input  busy,
        input  count_out,
        input  out_valid
    );

    modport slave (
        input  start,
        input  sbs_in,
        input  out_ready,
        output busy,
        output count_out,
        output out_valid
    );
endinterface

// File: rtl/sbs_to_binary.sv
// sbs_to_binary: counts ones of a stochastic bit stream over WINDOW cycles
// after discarding SKIP cycles, and hands the count out over valid/ready.
// Optional build macro: SBS_AUTORESTART_EN -- when defined, a completed
// handshake starts the next window immediately (no SKIP, no start needed).
module sbs_to_binary #(
    parameter int WINDOW = 15,
    parameter int SKIP   = 2,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    sbs_to_binary_if.slave    bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The cycle counter serves both the SKIP phase and the COUNT phase, so it
    // must hold whichever terminal value is larger.
    localparam int SKIPW = $clog2(SKIP + 1);
    localparam int CNTW  = (CW > SKIPW) ? CW : SKIPW;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   acc_sum;

    // Running sum including the current sample; also the final result on the
    // last sample of the window.
    always_comb begin
        acc_sum = acc_q + {{(CW-1){1'b0}}, bus.sbs_in};
    end

    // Next-state and datapath logic for the conversion FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (bus.start) begin
                    state_d = (SKIP == 0) ? ST_COUNT : ST_SKIP;
                end
            end
            ST_SKIP: begin
                // Generator pipeline flush: sbs_in is deliberately ignored.
                if (cnt_q == CNTW'(SKIP - 1)) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COUNT: begin
                acc_d = acc_sum;
                if (cnt_q == CNTW'(WINDOW - 1)) begin
                    count_d = acc_sum;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Result is held until accepted; start has no effect here.
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
`ifdef SBS_AUTORESTART_EN
                    state_d = ST_COUNT;
                    acc_d   = '0;
                    cnt_d   = '0;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy      = (state_q == ST_SKIP) || (state_q == ST_COUNT);
    assign bus.count_out = count_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sbs_to_binary.sv
// Testbench for sbs_to_binary: default DUT (WINDOW=15, SKIP=2, CW=4) and a
// short-window DUT (WINDOW=7, SKIP=0, CW=3). Expected counts go into a queue
// per DUT when the stimulus is driven; a negedge monitor pops and compares
// on every accepted result.
module tb_sbs_to_binary;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int qa[$];
    int qb[$];

    sbs_to_binary_if #(.CW(4)) a_if ();
    sbs_to_binary_if #(.CW(3)) b_if ();

    sbs_to_binary #(.WINDOW(15), .SKIP(2), .CW(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    sbs_to_binary #(.WINDOW(7), .SKIP(0), .CW(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: one line per accepted result.
    always @(negedge clk) begin
        if (!rst && a_if.out_valid && a_if.out_ready) begin
            check("a_queue_nonempty", qa.size() > 0, 1);
            if (qa.size() > 0) begin
                int e;
                e = qa.pop_front();
                $display("a result: count_out=%0d expected=%0d", a_if.count_out, e);
                check("a_count", a_if.count_out, e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_if.out_valid && b_if.out_ready) begin
            check("b_queue_nonempty", qb.size() > 0, 1);
            if (qb.size() > 0) begin
                int e;
                e = qb.pop_front();
                $display("b result: count_out=%0d expected=%0d", b_if.count_out, e);
                check("b_count", b_if.count_out, e);
            end
        end
    end

    // One conversion on DUT A. mode 0: all zeros, 1: all ones,
    // 2: 1,0,1,0... starting on the first COUNT sample. Bits driven during
    // SKIP are chosen so that counting them would change the result.
    task automatic conv_a(input int mode, input bit rdy);
        int exp_cnt;
        int busy_n;
        exp_cnt = 0;
        busy_n  = 0;
        for (int k = 1; k <= 15; k++) begin
            exp_cnt += (mode == 1) ? 1 : (mode == 2) ? (k % 2) : 0;
        end
        qa.push_back(exp_cnt);
        a_if.out_ready = rdy;
        a_if.start     = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            if (j <= 2) begin
                a_if.sbs_in = (mode == 0);
            end else begin
                a_if.sbs_in = (mode == 1) ? 1'b1 : (mode == 2) ? 1'((j - 2) % 2) : 1'b0;
            end
            if (a_if.busy && !a_if.out_valid) busy_n++;
            tick();
        end
        check("a_busy_cycles", busy_n, 17);
        check("a_valid_rise", a_if.out_valid, 1);
        check("a_busy_in_done", a_if.busy, 0);
    endtask

    initial begin
        int lat;
        a_if.start = 1'b0; a_if.sbs_in = 1'b0; a_if.out_ready = 1'b0;
        b_if.start = 1'b0; b_if.sbs_in = 1'b0; b_if.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_busy", a_if.busy, 0);
        check("rst_count", a_if.count_out, 0);
        check("rst_valid", a_if.out_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

`ifndef SBS_AUTORESTART_EN
        // All ones, ready already high: handshake on the edge after valid.
        conv_a(1, 1'b1);
        tick();
        check("a_valid_drop", a_if.out_valid, 0);
        check("a_idle_busy", a_if.busy, 0);

        // All zeros.
        conv_a(0, 1'b1);
        tick();
        check("a_valid_drop0", a_if.out_valid, 0);

        // Alternating stream, consumer stalls 5 cycles, start pulsed in DONE.
        conv_a(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_if.start = (i == 2);
            check("a_hold_valid", a_if.out_valid, 1);
            check("a_hold_count", a_if.count_out, 8);
            tick();
        end
        a_if.start = 1'b0;
        check("a_hold_busy", a_if.busy, 0);
        // start and out_ready together: only the handshake takes effect.
        a_if.out_ready = 1'b1;
        a_if.start     = 1'b1;
        tick();
        a_if.start     = 1'b0;
        a_if.out_ready = 1'b0;
        check("a_hs_valid", a_if.out_valid, 0);
        check("a_hs_busy", a_if.busy, 0);
        tick();
        check("a_start_not_queued", a_if.busy, 0);
        check("a_count_kept", a_if.count_out, 8);

        // Reset during the 6th COUNT cycle discards the partial window.
        a_if.sbs_in = 1'b1;
        a_if.start  = 1'b1;
        tick();
        a_if.start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("a_busy_pre_rst", a_if.busy, 1);
        rst = 1'b1;
        #1;
        check("a_rst_busy", a_if.busy, 0);
        check("a_rst_count", a_if.count_out, 0);
        check("a_rst_valid", a_if.out_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        conv_a(1, 1'b1);
        tick();
        check("a_after_rst_drop", a_if.out_valid, 0);
`else
        // Autorestart: one start, then a result every 16 cycles.
        a_if.sbs_in    = 1'b1;
        a_if.out_ready = 1'b1;
        for (int r = 0; r < 3; r++) qa.push_back(15);
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        lat = 1;
        while (!a_if.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("a_first_latency", lat, 18);
        for (int r = 0; r < 2; r++) begin
            lat = 0;
            do begin
                tick();
                lat++;
                if (lat == 1) check("a_auto_busy", a_if.busy, 1);
            end while (!a_if.out_valid && lat < 40);
            check("a_auto_period", lat, 16);
        end
        tick();
        a_if.out_ready = 1'b0;
`endif

        // Short window, no skip: valid 7 edges after the start edge.
        b_if.sbs_in    = 1'b1;
        b_if.out_ready = 1'b0;
        qb.push_back(7);
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        lat = 0;
        while (!b_if.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("b_latency", lat, 7);
        b_if.out_ready = 1'b1;
        tick();
        b_if.out_ready = 1'b0;
        check("b_valid_drop", b_if.out_valid, 0);
        tick();

        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global bound in case the DUT never produces an expected event.
    initial begin
        #50000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
